// File: rtl/seg7_pkg.sv
// Definitions shared by the digit scanner and the 7-segment decoder:
// the blank code, the digit type and the digit-index width helper.
package seg7_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [3:0] bcd_digit_t;

    function automatic int digit_idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_digit_scanner_if.sv
// Frame-load handshake between a frame producer and the digit scanner.
interface seg7_digit_scanner_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/seg7_lz_blank.sv
// Leading-zero mask: flags every digit that is zero and has only zeros above it.
// Digit 0 is never flagged; a 4'hF digit counts as non-zero.
module seg7_lz_blank
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   blank
);

    logic       zero_run_s;
    bcd_digit_t digit_s;

    // Walk from the most significant digit down, tracking an unbroken run of zeros.
    always_comb begin
        blank      = '0;
        zero_run_s = blank_lz;
        digit_s    = BLANK_CODE;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            digit_s    = digits[4*k +: 4];
            zero_run_s = zero_run_s && (digit_s == 4'h0);
            blank[k]   = zero_run_s;
        end
        blank[0] = 1'b0;
    end

endmodule

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed digit scanner: double-buffered frame, per-slot anti-ghost gap,
// optional leading-zero suppression, registered digit code and active-low enables.
module seg7_digit_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int IDX_W       = digit_idx_width(NUM_DIGITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_digit_scanner_if.slave    load,
    input  logic                   blank_lz,
    output bcd_digit_t             bcd,
    output logic [NUM_DIGITS-1:0]  an,
    output logic [IDX_W-1:0]       digit_idx,
    output logic                   frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      TERM_CNT  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GAP_CNT   = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]        cnt_r, cnt_next_s;
    logic [IDX_W-1:0]        idx_r, idx_next_s;
    logic                    frame_done_r;
    logic [4*NUM_DIGITS-1:0] pend_r, disp_r, disp_next_s;
    logic                    pend_full_r, ready_r, shown_r, shown_next_s;
    logic [NUM_DIGITS-1:0]   an_r, an_next_s, blank_mask_s;
    bcd_digit_t              bcd_r, bcd_next_s;
    logic                    term_s, boundary_s, accept_s, commit_s;

    assign term_s       = (cnt_r == TERM_CNT);
    assign boundary_s   = term_s && (idx_r == LAST_IDX);
    assign accept_s     = load.load_valid && ready_r;
    assign commit_s     = boundary_s && pend_full_r;
    assign disp_next_s  = commit_s ? pend_r : disp_r;
    // Enables stay dark until the first frame has been committed after reset.
    assign shown_next_s = shown_r || commit_s;

    // Next refresh count and slot index.
    always_comb begin
        cnt_next_s = cnt_r + CNT_W'(1);
        idx_next_s = idx_r;
        if (term_s) begin
            cnt_next_s = '0;
            if (idx_r == LAST_IDX) begin
                idx_next_s = '0;
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_next_s = idx_r;
        end
    end

    seg7_lz_blank #(.NUM_DIGITS(NUM_DIGITS)) u_lz_blank (
        .digits   (disp_next_s),
        .blank_lz (blank_lz),
        .blank    (blank_mask_s)
    );

    // Next digit code and enables, aligned with the next slot state.
    always_comb begin
        an_next_s  = '1;
        bcd_next_s = BLANK_CODE;
        if (shown_next_s && (cnt_next_s >= GAP_CNT)) begin
            an_next_s = ~(ONE_HOT_0 << idx_next_s);
            if (blank_mask_s[idx_next_s]) begin
                bcd_next_s = BLANK_CODE;
            end else begin
                bcd_next_s = disp_next_s[{idx_next_s, 2'b00} +: 4];
            end
        end else begin
            an_next_s  = '1;
            bcd_next_s = BLANK_CODE;
        end
    end

    // Refresh counter, slot index and end-of-scan pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= '0;
            idx_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_next_s;
            idx_r        <= idx_next_s;
            frame_done_r <= (cnt_next_s == TERM_CNT) && (idx_next_s == LAST_IDX);
        end
    end

    // Pending slot; ready lags the slot emptying by one cycle after a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r      <= {NUM_DIGITS{BLANK_CODE}};
            pend_full_r <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            ready_r <= !pend_full_r && !accept_s;
            if (accept_s) begin
                pend_r      <= load.load_data;
                pend_full_r <= 1'b1;
            end else if (commit_s) begin
                pend_full_r <= 1'b0;
            end
        end
    end

    // Display register and registered decoder-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_r  <= {NUM_DIGITS{BLANK_CODE}};
            shown_r <= 1'b0;
            an_r    <= '1;
            bcd_r   <= BLANK_CODE;
        end else begin
            disp_r  <= disp_next_s;
            shown_r <= shown_next_s;
            an_r    <= an_next_s;
            bcd_r   <= bcd_next_s;
        end
    end

    assign load.load_ready = ready_r;
    assign bcd             = bcd_r;
    assign an              = an_r;
    assign digit_idx       = idx_r;
    assign frame_done      = frame_done_r;

endmodule
